// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - multi-channel programmable clock divider with free-running counter
module clk_div_prog #(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 4,
    parameter int CH_W        = 2,
    parameter int DEFAULT_DIV = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    output logic [WIDTH-1:0]    free_cnt,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] free_cnt_q, free_cnt_d;
    logic             wr_valid;

    assign free_cnt_d = free_cnt_q + ONE;
    assign free_cnt   = free_cnt_q;
    assign wr_valid   = cfg_we && (32'(cfg_ch) < 32'(CHANNELS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_cnt_q <= '0;
        end else begin
            free_cnt_q <= free_cnt_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] div_q, div_d;
        logic [WIDTH-1:0] shd_q, shd_d;
        logic             tick_q, tick_d;
        logic             clk_q, clk_d;
        logic             pend_q, pend_d;
        logic             wr;

        assign wr = wr_valid && (32'(cfg_ch) == 32'(g));

        // Divisor only moves at a period boundary (terminal or idle); a write landing
        // exactly there bypasses the shadow so it is never left stranded as pending.
        always_comb begin
            cnt_d  = cnt_q;
            div_d  = div_q;
            shd_d  = wr ? cfg_div : shd_q;
            tick_d = tick_q;
            clk_d  = clk_q;
            pend_d = pend_q;
            if (!en[g]) begin
                cnt_d  = '0;
                tick_d = 1'b0;
                clk_d  = 1'b0;
                div_d  = wr ? cfg_div : (pend_q ? shd_q : div_q);
                pend_d = 1'b0;
            end else if (cnt_q == div_q) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                clk_d  = ~clk_q;
                div_d  = wr ? cfg_div : (pend_q ? shd_q : div_q);
                pend_d = 1'b0;
            end else begin
                cnt_d  = cnt_q + ONE;
                tick_d = 1'b0;
                pend_d = pend_q | wr;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                div_q  <= DEF_DIV;
                shd_q  <= DEF_DIV;
                tick_q <= 1'b0;
                clk_q  <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                shd_q  <= shd_d;
                tick_q <= tick_d;
                clk_q  <= clk_d;
                pend_q <= pend_d;
            end
        end

        assign tick[g]    = tick_q;
        assign clk_out[g] = clk_q;
        assign pending[g] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - randomized and directed checks of clk_div_prog against a behavioural model
module tb_clk_div_prog;

    localparam int W   = 4;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           cfg_we;
    logic [2:0]     cfg_ch;
    logic [W-1:0]   cfg_div;
    logic [W-1:0]   free_cnt;
    logic [NCH-1:0] tick, clk_out, pending;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit check_on  = 1'b0;

    clk_div_prog #(.WIDTH(W), .CHANNELS(NCH), .CH_W(3), .DEFAULT_DIV(0)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .free_cnt(free_cnt), .tick(tick), .clk_out(clk_out), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // Behavioural model: per channel, edges elapsed in the current period vs its divisor.
    int m_free;
    int m_age [NCH];
    int m_div [NCH];
    int m_sh  [NCH];
    bit m_tick[NCH];
    bit m_clk [NCH];
    bit m_pend[NCH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_free = 0;
            for (int c = 0; c < NCH; c++) begin
                m_age[c] = 0; m_div[c] = 0; m_sh[c] = 0;
                m_tick[c] = 0; m_clk[c] = 0; m_pend[c] = 0;
            end
        end else begin
            m_free = (m_free + 1) % (1 << W);
            for (int c = 0; c < NCH; c++) begin
                bit wr;
                wr = cfg_we && (int'(cfg_ch) == c);
                if (!en[c] || m_age[c] == m_div[c]) begin
                    if (en[c]) begin
                        m_tick[c] = 1;
                        m_clk[c]  = !m_clk[c];
                    end else begin
                        m_tick[c] = 0;
                        m_clk[c]  = 0;
                    end
                    m_age[c] = 0;
                    if (wr) m_div[c] = int'(cfg_div);
                    else if (m_pend[c]) m_div[c] = m_sh[c];
                    m_pend[c] = 0;
                end else begin
                    m_age[c]  = m_age[c] + 1;
                    m_tick[c] = 0;
                    if (wr) begin
                        m_sh[c]   = int'(cfg_div);
                        m_pend[c] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            logic [NCH-1:0] et, ec, ep;
            for (int c = 0; c < NCH; c++) begin
                et[c] = m_tick[c]; ec[c] = m_clk[c]; ep[c] = m_pend[c];
            end
            chk("model_free_cnt", 32'(free_cnt), 32'(m_free));
            chk("model_tick", 32'(tick), 32'(et));
            chk("model_clk_out", 32'(clk_out), 32'(ec));
            chk("model_pending", 32'(pending), 32'(ep));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div_idle(input int c, input int d);
        cfg_we = 1'b1; cfg_ch = 3'(c); cfg_div = W'(d);
        step();
        cfg_we = 1'b0;
        chk("idle_write_no_pending", 32'(pending[c]), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        repeat (3) step();
        chk("reset_free_cnt", 32'(free_cnt), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_clk_out", 32'(clk_out), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        check_on = 1'b1;

        for (int k = 1; k <= 20; k++) begin
            step();
            chk("free_wrap", 32'(free_cnt), 32'(k % 16));
        end

        // D=3 on ch0
        set_div_idle(0, 3);
        en[0] = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            step();
            chk("ratio3_tick0", 32'(tick[0]), 32'(k % 4 == 3));
            chk("ratio3_clk0", 32'(clk_out[0]), 32'(((k + 1) / 4) % 2));
        end

        // D=0 on ch0
        en[0] = 1'b0; step();
        set_div_idle(0, 0);
        en[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("d0_tick0", 32'(tick[0]), 32'd1);
            chk("d0_clk0", 32'(clk_out[0]), 32'(k % 2 == 0));
        end

        // Glitch-free update on ch1: 5 -> 1
        en = '0; step();
        set_div_idle(1, 5);
        en[1] = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            cfg_we = (k == 2); cfg_ch = 3'd1; cfg_div = 4'd1;
            step();
            chk("glitch_tick1", 32'(tick[1]), 32'(k == 5 || (k > 5 && (k - 5) % 2 == 0)));
            chk("glitch_pend1", 32'(pending[1]), 32'(k >= 2 && k <= 4));
        end
        cfg_we = 1'b0;

        // Back-to-back writes: 1 then 9, last wins
        en[1] = 1'b0; step();
        set_div_idle(1, 5);
        en[1] = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            cfg_we = (k == 2 || k == 3); cfg_ch = 3'd1; cfg_div = (k == 2) ? 4'd1 : 4'd9;
            step();
            chk("b2b_tick1", 32'(tick[1]), 32'(k == 5 || k == 15));
            chk("b2b_pend1", 32'(pending[1]), 32'(k >= 2 && k <= 4));
        end
        cfg_we = 1'b0;

        // Write coinciding with terminal count on ch2
        en = '0; step();
        set_div_idle(2, 2);
        en[2] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            cfg_we = (k == 2); cfg_ch = 3'd2; cfg_div = 4'd4;
            step();
            chk("term_tick2", 32'(tick[2]), 32'(k == 2 || k == 7));
            chk("term_pend2", 32'(pending[2]), 32'd0);
        end
        cfg_we = 1'b0;

        // Independence, invalid channel writes, ch2 restart
        en = '0; step();
        set_div_idle(0, 0); set_div_idle(1, 1); set_div_idle(2, 2); set_div_idle(3, 7);
        en = 4'hf;
        for (int k = 0; k <= 39; k++) begin
            logic [NCH-1:0] et;
            if (k == 10) en[2] = 1'b0;
            if (k == 13) en[2] = 1'b1;
            cfg_we  = (k >= 20 && k <= 23) || k == 25;
            cfg_ch  = (k == 25) ? 3'd3 : 3'(4 + (k - 20));
            cfg_div = (k == 25) ? 4'd2 : 4'd9;
            step();
            et[0] = 1'b1;
            et[1] = (k % 2 == 1);
            et[2] = (k < 10) ? (k % 3 == 2) : (k >= 13 && (k - 13) % 3 == 2);
            et[3] = (k <= 31) ? (k % 8 == 7) : ((k - 31) % 3 == 0);
            chk("indep_tick", 32'(tick), 32'(et));
            chk("indep_pending", 32'(pending), (k >= 25 && k < 31) ? 32'h8 : 32'h0);
        end
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 4'd5;
        step();
        cfg_we = 1'b0;
        chk("pre_rst_pending", 32'(pending), 32'h2);

        // Asynchronous reset mid-period
        #2 rst = 1'b1;
        #1;
        chk("async_free_cnt", 32'(free_cnt), 32'd0);
        chk("async_tick", 32'(tick), 32'd0);
        chk("async_clk_out", 32'(clk_out), 32'd0);
        chk("async_pending", 32'(pending), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_default_div", 32'(tick), 32'hf);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
            cfg_we  = ($urandom_range(0, 3) == 0);
            cfg_ch  = 3'($urandom_range(0, 7));
            cfg_div = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            step();
        end
        cfg_we = 1'b0;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Parametrised, multi-channel programmable clock divider: the successor to the team's free-running 32-bit divider counter. It keeps the free-running count output, so existing bit-tap consumers such as display scan and marquee shift still work. It adds CHANNELS independently enabled channels, each with a runtime-programmable divide ratio, a one-cycle tick strobe and a 50%-duty divided square output. Ratio changes are glitch-free: they take effect only at a channel's terminal count. The block sits at the top level beside the board clock and feeds the scan, shift and debounce logic.

## Interface
- WIDTH, 32, width of free-running counter, channel counters and divisors
- CHANNELS, 4, number of divider channels (1..16)
- CH_W, 2, width of cfg_ch; must satisfy 2^CH_W >= CHANNELS
- DEFAULT_DIV, 0, divisor D loaded into every channel at reset
- clk  in  1  single system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  CHANNELS  per-channel run enable, sampled on clk
- cfg_we  in  1  divisor write strobe, one cycle per write
- cfg_ch  in  CH_W  target channel of write
- cfg_div  in  WIDTH  new divisor value D
- free_cnt  out  WIDTH  free-running counter
- tick  out  CHANNELS  one-cycle strobe per channel period
- clk_out  out  CHANNELS  divided square wave, toggles at each tick
- pending  out  CHANNELS  shadow divisor written, not yet applied

## Operation
- Reset (async, immediate) sets the following:
  - free_cnt=0, tick=0, clk_out=0, pending=0
  - every channel counter cnt=0
  - every active divisor D=DEFAULT_DIV and shadow S=DEFAULT_DIV
- free_cnt increments by 1 every cycle and is independent of en and cfg.
  - Wraps from 2^WIDTH-1 to 0 with no flag.
- Per channel, each rising edge:
  - en=0: cnt<=0, tick<=0, clk_out<=0. Any pending S is copied to D and pending clears.
  - en=1 and cnt==D (terminal): cnt<=0, tick<=1, clk_out<=~clk_out. If pending, D<=S and pending clears.
  - en=1 otherwise: cnt<=cnt+1, tick<=0.
- Resulting periods: tick period = D+1 cycles; clk_out period = 2(D+1) cycles.
  - D=0 gives tick high continuously and clk_out = clk/2.
  - D=2^WIDTH-1 is legal. cnt never exceeds D, so there is no counter overflow.
- Write (cfg_we=1, cfg_ch<CHANNELS): S[cfg_ch]<=cfg_div, pending[cfg_ch]<=1.
  - cfg_ch>=CHANNELS: write ignored, no state changes.
- Write in the same cycle as that channel's terminal count, or while that channel has en=0:
  - D<=cfg_div directly, pending stays 0. The write wins over the old S.
- Back-to-back writes to one channel before its terminal count: the last write wins, and pending stays 1.
- A write never alters cnt, tick or clk_out of any channel. The current period always completes with the old D.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- en edge timing:
  - Let e0 be the first edge sampling en=1, with cnt=0 already.
  - The first tick goes high after edge e0+D and lasts exactly one cycle.
  - en deasserting clears tick and clk_out after the next edge.
- Divisor and pending timing:
  - A new D governs the period starting right after the tick edge at which it is applied.
  - pending rises the cycle after the write edge and falls the cycle after the apply edge.
- Async rst mid-period: all outputs are forced low immediately and all written divisors are lost (back to DEFAULT_DIV).
- Write latency to visible effect: at most D_old+1 cycles while running, one edge while disabled.

## Test plan
- Reset/free-run, WIDTH=4:
  - Assert rst mid-count -> free_cnt, tick, clk_out and pending go to 0 with no clock edge.
  - Release rst -> free_cnt counts 0..15, then 0, wrapping every 16 cycles.
- Ratio, D=3 on ch0, en0 rising before edge 0:
  - tick0 high after edges 3, 7, 11.
  - clk_out0 high over cycles 4-7, low over cycles 8-11.
- D=0:
  - tick held at 1 continuously.
  - clk_out toggles every cycle.
- Glitch-free update:
  - Setup: ch1 running with D=5; write cfg_div=1 at cycle 2 of a period.
  - pending1=1 until the tick; the current period still lasts 6 cycles; later ticks come every 2 cycles.
  - A second write (cfg_div=9) before that tick -> D=9 is applied, not 1.
- Disabled and edge-case writes:
  - Write to a channel with en=0 -> D is updated at once and pending stays 0.
  - Write coinciding with the terminal count -> pending stays 0 and the next period uses the new D.
  - cfg_ch=CHANNELS -> no channel changes.
- Independence:
  - Setup: 4 channels with D=0, 1, 2, 7; toggle en2 mid-period.
  - Channels 0, 1 and 3 keep exact tick spacing.
  - ch2 restarts with its first tick 3 cycles after re-enable.
